pong_frame_scheduler: RTL and testbench
=======================================

# pong_frame_scheduler

Per-frame update sequencer for the Pong display pipeline. Watches the horizontal/vertical raster counts, derives the active-video window, and at the start of each vertical blanking interval issues a fixed, ordered series of game-update tasks (input sampling, paddle move, ball move, collision/score) over a req/done handshake. Each task must finish inside vblank, or the frame is flagged as an overrun. It sits between the raster counters and the game-logic blocks, so no game state changes while pixels are being drawn.

## Interface
- `H_TOTAL`, 800: horizontal count period (counts 0..799).
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines.
- `V_TOTAL`, 525: vertical count period (counts 0..524).
- `NUM_TASKS`, 4: number of sequenced tasks; legal range 1..8.
- `TASK_TIMEOUT`, 4095: per-task cycle limit; used only with the watchdog.

- `clk` in 1: pixel clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `x_count` in 10: horizontal raster count.
- `y_count` in 10: vertical raster count.
- `task_done` in NUM_TASKS: one bit per task; pulse or level.
- `overrun_clr` in 1: clears `overrun` (and `timeout`).
- `video_on` out 1: combinational; high when `x_count < H_ACTIVE && y_count < V_ACTIVE`.
- `frame_tick` out 1: one-cycle pulse at the start of each update sequence.
- `task_req` out NUM_TASKS: one-hot or zero; held until the matching done.
- `busy` out 1: high while a sequence is in progress.
- `overrun` out 1: sticky; set when a sequence is aborted at vblank end.
- `timeout` out 1: sticky watchdog flag; tied 0 without `PONG_SCHED_WATCHDOG_EN`.
- `frame_count` out 8: count of completed sequences; wraps 255→0.

## Operation
- Events, decoded combinationally from the raster inputs:
  - vs_start: `x_count == H_TOTAL-1 && y_count == V_ACTIVE-1`.
  - vs_end: `x_count == H_TOTAL-1 && y_count == V_TOTAL-1`.
- FSM states: IDLE, RUN, with task index `idx`.
- IDLE:
  - On vs_start: go to RUN, set `idx = 0`, `task_req = 1<<0`, `frame_tick = 1`, `busy = 1`.
  - Otherwise hold, with `task_req = 0`.
- RUN, when `task_done[idx]` is sampled high:
  - If `idx < NUM_TASKS-1`: `idx+1` and `task_req = 1<<(idx+1)` on the same edge. There is no idle gap.
  - Else: `task_req = 0`, `busy = 0`, `frame_count++`, go to IDLE.
- `task_done` bits other than `[idx]` are ignored, in every state.
- RUN, when vs_end is sampled and the last task's done is not sampled on that edge: abort. Set `task_req = 0`, `busy = 0`, `overrun = 1`, go to IDLE. `frame_count` is not incremented.
- Simultaneous events:
  - Last `task_done` and vs_end on the same cycle: the sequence counts as complete, with no overrun.
  - `overrun_clr` together with a new overrun: the set wins.
- vs_start cannot occur in RUN, because vs_end precedes it. If raster inputs jump (illegal), vs_start in RUN is ignored.
- Reset, asynchronous and valid at any point including mid-sequence: state IDLE, `idx = 0`, `task_req = 0`, `frame_tick = 0`, `busy = 0`, `overrun = 0`, `timeout = 0`, `frame_count = 0`, watchdog counter 0.

## Timing
- All outputs except `video_on` are registered.
- `frame_tick` and `task_req[0]` go high the cycle after the vs_start cycle.
- Handshake latency: when done is sampled at edge N, the next request is visible after edge N.
- Budget: vblank is (V_TOTAL-V_ACTIVE)·H_TOTAL = 36000 cycles at defaults.

## Configuration
- `PONG_SCHED_WATCHDOG_EN` defined:
  - A per-task counter resets on each new request.
  - When the counter reaches `TASK_TIMEOUT` cycles without done, the current task is skipped as if done, and `timeout` is set sticky.
  - If the skipped task is the last one, the sequence completes and `frame_count` increments.
- `PONG_SCHED_WATCHDOG_EN` undefined:
  - No counter logic.
  - `timeout` is constant 0.
  - A task waits for done or vs_end.

## Structure
- `pong_timing_pkg` holds:
  - The H_TOTAL/H_ACTIVE/V_ACTIVE/V_TOTAL constants.
  - The state enum `sched_state_t` {IDLE, RUN}.
  - The task index constants (TASK_INPUT=0, TASK_PADDLE=1, TASK_BALL=2, TASK_COLLIDE=3).
- Sub-module `task_watchdog` holds the counter and compare. It is instantiated only under `PONG_SCHED_WATCHDOG_EN`.

## Test plan
- Reset mid-RUN with `task_req = 4'b0100` → all outputs 0 immediately; the next vs_start restarts at `task_req = 4'b0001`.
- Each task done 3 cycles after its request, at (x=799, y=479) → `frame_tick` pulses once, `task_req` steps 0001→0010→0100→1000→0000, `frame_count` 0→1, `overrun = 0`.
- Task 2 never done, watchdog off → at (799, 524) `task_req` drops to 0, `overrun = 1`, `frame_count` unchanged. `overrun_clr` then clears it.
- Last done coincident with (799, 524) → complete, `frame_count` increments, `overrun = 0`.
- Watchdog on, `TASK_TIMEOUT = 16`, task 1 silent → after 16 cycles `task_req = 0100`, `timeout = 1`, sequence completes.
- Spurious `task_done = 4'b1111` in IDLE, and `task_done[3]` while `idx = 0` → no state change.
- `video_on` sweep: (639, 479) → 1; (640, 0) → 0; (0, 480) → 0.

Source files
------------

// File: rtl/pong_timing_pkg.sv
// Shared raster timing constants, scheduler state encoding and task slot indices
// for the Pong frame scheduler.
package pong_timing_pkg;

   localparam int H_TOTAL  = 800;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int V_TOTAL  = 525;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sched_state_t;

   // Fixed order in which the game-logic blocks are serviced each frame.
   localparam int TASK_INPUT   = 0;
   localparam int TASK_PADDLE  = 1;
   localparam int TASK_BALL    = 2;
   localparam int TASK_COLLIDE = 3;

endpackage

// File: rtl/task_watchdog.sv
// Per-task cycle counter: flags expiry once a request has been outstanding for
// TASK_TIMEOUT cycles. Only instantiated when PONG_SCHED_WATCHDOG_EN is defined.
module task_watchdog #(
   parameter int TASK_TIMEOUT = 4095
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_run,
   input  logic i_clear,
   output logic o_expired
);

   localparam int CW = (TASK_TIMEOUT > 1) ? $clog2(TASK_TIMEOUT) : 1;

   logic [CW-1:0] r_cnt;

   // Count is 0 on the first cycle a request is visible, so expiry on count
   // TASK_TIMEOUT-1 leaves the request up for exactly TASK_TIMEOUT cycles.
   assign o_expired = i_run && (r_cnt == CW'(TASK_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (!i_run || i_clear) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pong_frame_scheduler.sv
// Vblank game-update sequencer: issues NUM_TASKS ordered req/done tasks per frame.
// Optional per-task watchdog enabled by defining PONG_SCHED_WATCHDOG_EN.
module pong_frame_scheduler
   import pong_timing_pkg::*;
#(
   parameter int H_TOTAL      = pong_timing_pkg::H_TOTAL,
   parameter int H_ACTIVE     = pong_timing_pkg::H_ACTIVE,
   parameter int V_ACTIVE     = pong_timing_pkg::V_ACTIVE,
   parameter int V_TOTAL      = pong_timing_pkg::V_TOTAL,
   parameter int NUM_TASKS    = 4,
   parameter int TASK_TIMEOUT = 4095
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [9:0]           x_count,
   input  logic [9:0]           y_count,
   input  logic [NUM_TASKS-1:0] task_done,
   input  logic                 overrun_clr,
   output logic                 video_on,
   output logic                 frame_tick,
   output logic [NUM_TASKS-1:0] task_req,
   output logic                 busy,
   output logic                 overrun,
   output logic                 timeout,
   output logic [7:0]           frame_count,
   output sched_state_t         dbg_state
);

   if (NUM_TASKS < 1 || NUM_TASKS > 8) begin : g_bad_num_tasks
      $error("NUM_TASKS must be in 1..8");
   end
   if (TASK_TIMEOUT < 1) begin : g_bad_timeout
      $error("TASK_TIMEOUT must be at least 1");
   end

   sched_state_t         r_state, w_state_nxt;
   logic [2:0]           r_idx, w_idx_nxt;
   logic                 r_tick, w_tick_nxt;
   logic [NUM_TASKS-1:0] r_req, w_req_nxt;
   logic                 r_busy, w_busy_nxt;
   logic                 r_overrun, w_overrun_nxt;
   logic [7:0]           r_fc, w_fc_nxt;

   logic       w_vs_start, w_vs_end;
   logic [7:0] w_done_ext;
   logic       w_done_cur, w_expired, w_step, w_last;

   assign video_on   = (x_count < 10'(H_ACTIVE)) && (y_count < 10'(V_ACTIVE));
   assign w_vs_start = (x_count == 10'(H_TOTAL - 1)) && (y_count == 10'(V_ACTIVE - 1));
   assign w_vs_end   = (x_count == 10'(H_TOTAL - 1)) && (y_count == 10'(V_TOTAL - 1));

   // Widen to 8 bits so the 3-bit index never selects past the port.
   always_comb begin
      w_done_ext                = '0;
      w_done_ext[NUM_TASKS-1:0] = task_done;
   end

   assign w_done_cur = w_done_ext[r_idx];
   assign w_step     = (r_state == RUN) && (w_done_cur || w_expired);
   assign w_last     = (r_idx == 3'(NUM_TASKS - 1));

`ifdef PONG_SCHED_WATCHDOG_EN
   logic r_timeout;

   task_watchdog #(
      .TASK_TIMEOUT (TASK_TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_run     (r_state == RUN),
      .i_clear   (w_step),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_timeout <= 1'b0;
      end else if (w_expired) begin
         r_timeout <= 1'b1;
      end else if (overrun_clr) begin
         r_timeout <= 1'b0;
      end
   end

   assign timeout = r_timeout;
`else
   assign w_expired = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_tick_nxt    = 1'b0;
      w_req_nxt     = r_req;
      w_busy_nxt    = r_busy;
      w_overrun_nxt = r_overrun && !overrun_clr;
      w_fc_nxt      = r_fc;
      case (r_state)
         IDLE: begin
            w_req_nxt = '0;
            if (w_vs_start) begin
               w_state_nxt = RUN;
               w_idx_nxt   = 3'(TASK_INPUT);
               w_req_nxt   = NUM_TASKS'(1) << TASK_INPUT;
               w_tick_nxt  = 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end
         RUN: begin
            // A finished last task beats vs_end; anything else at vs_end aborts.
            if (w_step && w_last) begin
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
               w_req_nxt   = '0;
               w_busy_nxt  = 1'b0;
               w_fc_nxt    = r_fc + 8'd1;
            end else if (w_vs_end) begin
               w_state_nxt   = IDLE;
               w_idx_nxt     = '0;
               w_req_nxt     = '0;
               w_busy_nxt    = 1'b0;
               w_overrun_nxt = 1'b1;
            end else if (w_step) begin
               w_idx_nxt = r_idx + 3'd1;
               w_req_nxt = r_req << 1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_req_nxt   = '0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_tick    <= 1'b0;
         r_req     <= '0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
         r_fc      <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_tick    <= w_tick_nxt;
         r_req     <= w_req_nxt;
         r_busy    <= w_busy_nxt;
         r_overrun <= w_overrun_nxt;
         r_fc      <= w_fc_nxt;
      end
   end

   assign frame_tick  = r_tick;
   assign task_req    = r_req;
   assign busy        = r_busy;
   assign overrun     = r_overrun;
   assign frame_count = r_fc;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_pong_frame_scheduler.sv
// Directed self-checking bench for pong_frame_scheduler (default 4 tasks);
// exercises the watchdog path when PONG_SCHED_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_pong_frame_scheduler;
   import pong_timing_pkg::*;

   localparam int NT = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [9:0]    x_count, y_count;
   logic [NT-1:0] task_done;
   logic          overrun_clr;
   logic          video_on, frame_tick, busy, overrun, timeout;
   logic [NT-1:0] task_req;
   logic [7:0]    frame_count;
   sched_state_t  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   logic [NT-1:0] exp_q[$];

   always #5 clk = ~clk;

   pong_frame_scheduler #(
      .NUM_TASKS    (NT),
      .TASK_TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .x_count     (x_count),
      .y_count     (y_count),
      .task_done   (task_done),
      .overrun_clr (overrun_clr),
      .video_on    (video_on),
      .frame_tick  (frame_tick),
      .task_req    (task_req),
      .busy        (busy),
      .overrun     (overrun),
      .timeout     (timeout),
      .frame_count (frame_count),
      .dbg_state   (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_raster(input int x, input int y);
      x_count = 10'(x);
      y_count = 10'(y);
   endtask

   task automatic pulse_done(input int b);
      task_done = NT'(1 << b);
      step(1);
      task_done = '0;
   endtask

   task automatic check_req_q(input string tag);
      logic [NT-1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_qempty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check(tag, 32'(task_req), 32'(e));
      end
   endtask

   task automatic start_frame();
      set_raster(799, 479);
      step(1);
      set_raster(100, 490);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      reset_n     = 1'b0;
      task_done   = '0;
      overrun_clr = 1'b0;
      set_raster(0, 0);
      step(3);
      check("rst_req", 32'(task_req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tick", 32'(frame_tick), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_fc", 32'(frame_count), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      reset_n = 1'b1;
      step(2);

      // video_on sweep
      set_raster(639, 479); #1; check("von_639_479", 32'(video_on), 32'd1);
      set_raster(640, 0);   #1; check("von_640_0", 32'(video_on), 32'd0);
      set_raster(0, 480);   #1; check("von_0_480", 32'(video_on), 32'd0);
      set_raster(0, 0);     #1; check("von_0_0", 32'(video_on), 32'd1);
      step(1);

      // Normal frame: each task done 3 cycles after its request
      start_frame();
      check("nf_tick", 32'(frame_tick), 32'd1);
      check("nf_req0", 32'(task_req), 32'd1);
      check("nf_busy", 32'(busy), 32'd1);
      check("nf_state", 32'(dbg_state), 32'(RUN));
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0000);
      for (int i = 0; i < NT; i++) begin
         step(1);
         if (i == 0) check("nf_tick_once", 32'(frame_tick), 32'd0);
         step(1);
         check($sformatf("nf_hold%0d", i), 32'(task_req), 32'(1 << i));
         pulse_done(i);
         check_req_q($sformatf("nf_next%0d", i));
      end
      check("nf_busy_end", 32'(busy), 32'd0);
      check("nf_fc", 32'(frame_count), 32'd1);
      check("nf_overrun", 32'(overrun), 32'd0);
      check("nf_state_end", 32'(dbg_state), 32'(IDLE));

      // Spurious done in IDLE
      task_done = 4'b1111;
      step(2);
      task_done = '0;
      check("sp_idle_req", 32'(task_req), 32'd0);
      check("sp_idle_busy", 32'(busy), 32'd0);
      check("sp_idle_fc", 32'(frame_count), 32'd1);

      // Done for a non-current task is ignored; then task 2 never finishes
      start_frame();
      check("ov_req0", 32'(task_req), 32'd1);
      task_done = 4'b1000;
      step(1);
      task_done = '0;
      check("sp_wrong_bit", 32'(task_req), 32'd1);
      pulse_done(TASK_INPUT);
      check("ov_req1", 32'(task_req), 32'd2);
      pulse_done(TASK_PADDLE);
      check("ov_req2", 32'(task_req), 32'd4);
`ifndef PONG_SCHED_WATCHDOG_EN
      step(40);
      check("ov_wait_req", 32'(task_req), 32'd4);
      check("ov_wait_to", 32'(timeout), 32'd0);
`endif
      set_raster(799, 524);
      step(1);
      set_raster(0, 0);
      check("ov_req_drop", 32'(task_req), 32'd0);
      check("ov_flag", 32'(overrun), 32'd1);
      check("ov_busy", 32'(busy), 32'd0);
      check("ov_fc", 32'(frame_count), 32'd1);
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
      check("ov_clr", 32'(overrun), 32'd0);

      // Non-last done at vs_end still aborts; clear coincident with set loses
      start_frame();
      pulse_done(TASK_INPUT);
      set_raster(799, 524);
      task_done   = 4'b0010;
      overrun_clr = 1'b1;
      step(1);
      task_done   = '0;
      overrun_clr = 1'b0;
      set_raster(0, 0);
      check("sw_flag", 32'(overrun), 32'd1);
      check("sw_fc", 32'(frame_count), 32'd1);
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
      check("sw_clr", 32'(overrun), 32'd0);

      // Last done coincident with vs_end completes the frame
      start_frame();
      pulse_done(TASK_INPUT);
      pulse_done(TASK_PADDLE);
      pulse_done(TASK_BALL);
      check("co_req3", 32'(task_req), 32'd8);
      set_raster(799, 524);
      task_done = 4'b1000;
      step(1);
      task_done = '0;
      set_raster(0, 0);
      check("co_req", 32'(task_req), 32'd0);
      check("co_fc", 32'(frame_count), 32'd2);
      check("co_overrun", 32'(overrun), 32'd0);
      check("co_busy", 32'(busy), 32'd0);

      // Asynchronous reset mid-sequence
      start_frame();
      pulse_done(TASK_INPUT);
      pulse_done(TASK_PADDLE);
      check("mr_req2", 32'(task_req), 32'd4);
      #2;
      reset_n = 1'b0;
      #1;
      check("mr_req", 32'(task_req), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_fc", 32'(frame_count), 32'd0);
      check("mr_tick", 32'(frame_tick), 32'd0);
      check("mr_state", 32'(dbg_state), 32'(IDLE));
      step(1);
      reset_n = 1'b1;
      start_frame();
      check("mr_restart_req", 32'(task_req), 32'd1);
      check("mr_restart_tick", 32'(frame_tick), 32'd1);
      for (int i = 0; i < NT; i++) pulse_done(i);
      check("mr_fc_after", 32'(frame_count), 32'd1);

`ifdef PONG_SCHED_WATCHDOG_EN
      // Watchdog: paddle task silent, skipped after 16 cycles
      start_frame();
      pulse_done(TASK_INPUT);
      check("wd_req1", 32'(task_req), 32'd2);
      step(15);
      check("wd_hold", 32'(task_req), 32'd2);
      check("wd_to_early", 32'(timeout), 32'd0);
      step(1);
      check("wd_skip", 32'(task_req), 32'd4);
      check("wd_timeout", 32'(timeout), 32'd1);
      pulse_done(TASK_BALL);
      pulse_done(TASK_COLLIDE);
      check("wd_fc", 32'(frame_count), 32'd2);
      check("wd_busy", 32'(busy), 32'd0);
      check("wd_overrun", 32'(overrun), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
